// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and default widths for the instruction fetch
//               sequencer (state encoding, bus widths, reset PC).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

    // IDLE is a one-cycle settle state after reset; DRAIN waits out a
    // wrong-path request that the memory has not yet acknowledged.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Redirect, instruction-memory and decode-side signals of the
//               fetch sequencer. master = sequencer view, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    // redirect from execute
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    // instruction memory
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    // decode
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_ack, imem_rdata,
        input  if_ready,
        output imem_req, imem_addr,
        output if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_ack, imem_rdata,
        output if_ready,
        input  imem_req, imem_addr,
        input  if_valid, if_instr, if_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_buf
// Description : One-entry valid/ready holding register for {instr, pc}
//               between fetch and decode. Flush beats load beats consume.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              consume_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_o
);

    logic              valid_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_q;

    // A load may coincide with a consume (back-to-back stream); a flush
    // only clears the valid flag, the payload is don't-care afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Owns the PC, issues one word fetch at a time over req/ack,
//               buffers returned instructions toward decode and applies
//               branch redirects, draining any wrong-path request in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter int                DATA_W   = DATA_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(1);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;        // address being fetched (stale one in DRAIN)
    logic [ADDR_W-1:0] pend_pc_q;   // redirect target to resume at after DRAIN
    logic              pending_q;   // request issued and not yet acknowledged

    logic              w_req;
    logic              w_ack;
    logic              w_load;
    logic              w_consume;
    logic              w_flush;
    logic              w_buf_valid;
    logic [DATA_W-1:0] w_buf_instr;
    logic [ADDR_W-1:0] w_buf_pc;

    // Request is open while an earlier one waits, or while the buffer is
    // empty or being drained this cycle; DRAIN must keep the old request up.
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            FETCH:   w_req = pending_q || !w_buf_valid || bus.if_ready;
            DRAIN:   w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    // An ack only means something while a request is actually presented.
    assign w_ack     = w_req && bus.imem_ack;
    assign w_load    = (state_q == FETCH) && w_ack && !bus.redirect_valid;
    assign w_consume = w_buf_valid && bus.if_ready;
    assign w_flush   = bus.redirect_valid;

    // Fetch control: PC advance, handshake tracking and redirect handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            pending_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid && w_req && !w_ack) begin
                        // memory holds a wrong-path request: wait it out
                        state_q   <= DRAIN;
                        pend_pc_q <= bus.redirect_pc;
                        pending_q <= 1'b1;
                    end else if (bus.redirect_valid) begin
                        pc_q      <= bus.redirect_pc;
                        pending_q <= 1'b0;
                    end else if (w_ack) begin
                        pc_q      <= pc_q + c_pc_step;
                        pending_q <= 1'b0;
                    end else if (w_req) begin
                        pending_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_ack) begin
                        state_q   <= FETCH;
                        pending_q <= 1'b0;
                        pc_q      <= bus.redirect_valid ? bus.redirect_pc : pend_pc_q;
                    end else begin
                        pending_q <= 1'b1;
                        if (bus.redirect_valid) begin
                            pend_pc_q <= bus.redirect_pc;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fetch_out_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_load),
        .consume_i (w_consume),
        .flush_i   (w_flush),
        .instr_i   (bus.imem_rdata),
        .pc_i      (pc_q),
        .valid_o   (w_buf_valid),
        .instr_o   (w_buf_instr),
        .pc_o      (w_buf_pc)
    );

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = w_buf_valid;
    assign bus.if_instr  = w_buf_instr;
    assign bus.if_pc     = w_buf_pc;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch: owns the program counter, issues one word address at a time to instruction memory over a req/ack handshake, and buffers each returned instruction with its PC toward decode under valid/ready. It sits between the instruction memory and the decode stage. It also applies branch/jump redirects, discarding wrong-path data, including a fetch already in flight.

## Interface
- ADDR_W, 32, PC / memory word-address width
- DATA_W, 32, instruction width
- RESET_PC, 0, PC value loaded by reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  one-cycle redirect pulse from execute
- redirect_pc  in  ADDR_W  redirect target, word address
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  word address of request
- imem_ack  in  1  response; imem_rdata valid this cycle; may be same cycle as req
- imem_rdata  in  DATA_W  instruction word
- if_valid  out  1  output buffer holds an instruction
- if_instr  out  DATA_W  buffered instruction
- if_pc  out  ADDR_W  PC of buffered instruction
- if_ready  in  1  decode accepts when if_valid && if_ready

## Operation
- States: IDLE, FETCH, DRAIN. Reset -> IDLE; IDLE -> FETCH unconditionally next cycle.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, pending=0.
- imem_addr = pc in FETCH; = stale in-flight address in DRAIN.
- FETCH: imem_req = pending || !if_valid || if_ready. Starts only when the buffer is empty or being consumed this cycle.
- Handshake: once imem_req is high without imem_ack, set pending. Hold req and addr stable until ack; clear pending on ack. At most one outstanding request.
- Ack in FETCH, no redirect: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+1.
- Consume without new ack: if_valid<=0.
- pc+1 wraps modulo 2^ADDR_W (all-ones -> 0).
- Redirect in FETCH, with no request outstanding or with ack this cycle:
  - if_valid<=0, ack data discarded, pc<=redirect_pc.
  - Stay FETCH.
- Redirect in FETCH with req high and no ack:
  - if_valid<=0, redirect_pc latched into pend_pc.
  - -> DRAIN.
- DRAIN:
  - imem_req=1 at the old address until ack; data discarded; if_valid stays 0.
  - On ack: pc<=pend_pc, -> FETCH.
- Redirect during DRAIN overwrites pend_pc (latest wins). Redirect and ack in the same DRAIN cycle: pc<=new redirect_pc, -> FETCH.
- A redirect always wins over a simultaneous consume/ack: the buffer is flushed even if if_ready=1.
- rst mid-operation: immediate return to reset values. An in-flight request is abandoned; the memory must tolerate req dropping under reset.

## Timing
- Zero-wait memory (ack same cycle as req), if_ready=1: one instruction per cycle. The first if_valid comes 2 cycles after rst deasserts, with if_pc=RESET_PC.
- Fetch latency: ack at cycle t -> if_valid/if_instr at t+1.
- Redirect at t, no in-flight request: imem_addr=redirect_pc at t+1; instruction valid at t+2 with zero-wait memory.
- Redirect while a request waits for ack at t+k: new address issued at t+k+1.
- if_ready low: the buffer holds and no new request starts. An already-pending request completes into the buffer.
- No combinational path from imem_rdata to outputs. imem_req depends combinationally on if_ready and if_valid.

## Structure
- Package fetch_pkg: state enum (IDLE, FETCH, DRAIN), ADDR_W/DATA_W defaults, RESET_PC default.
- Sub-module fetch_out_buf: one-entry valid/ready register holding {instr, pc}, with load, consume and flush inputs. The FSM, pc, pending and pend_pc stay in fetch_sequencer.

## Test plan
- Reset, zero-wait memory returning word n = 0x1000+n, if_ready=1:
  - if_pc sequence 0,1,2,3 on consecutive cycles.
  - if_instr 0x1000..0x1003.
- Backpressure: drop if_ready for 3 cycles after if_pc=2:
  - if_pc=2 held.
  - imem_req=0 while the buffer is full; resume at pc=3.
  - No skipped or duplicated PC.
- Memory with 3-cycle ack latency; redirect to 0x40 in the first wait cycle:
  - req/addr held stable until ack; ack data dropped.
  - Next imem_addr=0x40; first valid if_pc=0x40.
- Redirect to 0x80, then to 0xC0 during DRAIN:
  - After ack, fetch starts at 0xC0; 0x80 never fetched.
- Redirect coincident with ack and with if_ready=1 while if_valid=1:
  - Buffer flushed; acked word dropped.
  - Next valid if_pc=redirect_pc.
- Redirect to 0xFFFFFFFF: if_pc 0xFFFFFFFF then 0x00000000. Assert rst mid-DRAIN: outputs take reset values immediately.
